// File: rtl/rv32i_types.sv
// Shared core types: physical/architectural register counts, preg index type,
// and the rename/commit width used by the free list.
package rv32i_types;
  localparam int SS         = 2;
  localparam int PHYS_REGS  = 64;
  localparam int ARCH_REGS  = 32;
  localparam int PREG_W     = $clog2(PHYS_REGS);
  localparam int FL_DEPTH   = PHYS_REGS - ARCH_REGS;
  localparam int FL_PTR_W   = $clog2(FL_DEPTH) + 1;

  typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/free_list_if.sv
// Rename/commit side of the physical-register free list.
// Optional stall_cycles signal exists only with FREE_LIST_STALL_CNT_EN.
interface free_list_if;
  import rv32i_types::*;

  logic [SS-1:0]          alloc_req;
  logic                   alloc_ok;
  preg_t [SS-1:0]         alloc_preg;
  logic [SS-1:0]          free_valid;
  preg_t [SS-1:0]         free_preg;
  logic [SS-1:0]          commit_alloc;
  logic                   flush;
  logic [FL_PTR_W-1:0]    free_count;
  logic                   overflow_err;
`ifdef FREE_LIST_STALL_CNT_EN
  logic [31:0]            stall_cycles;
`endif

  modport master (
    output alloc_req, free_valid, free_preg, commit_alloc, flush,
    input  alloc_ok, alloc_preg, free_count, overflow_err
`ifdef FREE_LIST_STALL_CNT_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  alloc_req, free_valid, free_preg, commit_alloc, flush,
    output alloc_ok, alloc_preg, free_count, overflow_err
`ifdef FREE_LIST_STALL_CNT_EN
    , output stall_cycles
`endif
  );
endinterface

// File: rtl/free_list_compact.sv
// Prefix popcount: offset[i] = number of set mask bits below lane i.
module free_list_compact #(
  parameter int NUM_LANES = 2,
  parameter int CW        = $clog2(NUM_LANES + 1)
) (
  input  logic [NUM_LANES-1:0]         mask,
  output logic [NUM_LANES-1:0][CW-1:0] offset,
  output logic [CW-1:0]                total
);
  logic [CW-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      offset[i] = acc;
      acc       = acc + CW'(mask[i]);
    end
    total = acc;
  end
endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers with committed read pointer for
// single-cycle flush recovery. Optional stall counter: FREE_LIST_STALL_CNT_EN.
module free_list
  import rv32i_types::*;
(
  input logic        clk,
  input logic        rst_n,
  free_list_if.slave fl
);
  localparam int IW = $clog2(FL_DEPTH);
  localparam int PW = FL_PTR_W;
  localparam int CW = $clog2(SS + 1);

  preg_t         entry [FL_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, arch_rd_ptr;
  logic [PW-1:0] free_count, room;

  logic [SS-1:0][CW-1:0] a_off, f_off;
  logic [CW-1:0]         a_n, f_raw, c_n;
  logic [PW-1:0]         f_n;
  logic [SS-1:0]         free_mask, accept;
  logic [SS-1:0][IW-1:0] w_idx;
  logic                  alloc_ok, drop;

  assign free_count = wr_ptr - rd_ptr;
  assign room       = PW'(FL_DEPTH) - free_count;

  always_comb begin
    for (int s = 0; s < SS; s++) free_mask[s] = fl.free_valid[s] && (fl.free_preg[s] != '0);
  end

  free_list_compact #(.NUM_LANES(SS)) u_alloc_cmp (.mask(fl.alloc_req), .offset(a_off), .total(a_n));
  free_list_compact #(.NUM_LANES(SS)) u_free_cmp  (.mask(free_mask),    .offset(f_off), .total(f_raw));

  assign alloc_ok = (PW'(a_n) <= free_count) && !fl.flush;

  // Frees are compacted, so only the first `room` of them fit; the rest overflow.
  always_comb begin
    c_n          = '0;
    fl.alloc_preg = '0;
    for (int s = 0; s < SS; s++) begin
      c_n       = c_n + CW'(fl.commit_alloc[s]);
      accept[s] = free_mask[s] && (PW'(f_off[s]) < room);
      w_idx[s]  = wr_ptr[IW-1:0] + IW'(f_off[s]);
      if (fl.alloc_req[s]) fl.alloc_preg[s] = entry[rd_ptr[IW-1:0] + IW'(a_off[s])];
    end
    f_n  = (PW'(f_raw) > room) ? room : PW'(f_raw);
    drop = |(free_mask & ~accept);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr          <= '0;
      arch_rd_ptr     <= '0;
      wr_ptr          <= PW'(FL_DEPTH);
      fl.overflow_err <= 1'b0;
      for (int i = 0; i < FL_DEPTH; i++) entry[i] <= preg_t'(ARCH_REGS + i);
    end else begin
      if (fl.flush)       rd_ptr <= arch_rd_ptr + PW'(c_n);
      else if (alloc_ok)  rd_ptr <= rd_ptr + PW'(a_n);
      arch_rd_ptr     <= arch_rd_ptr + PW'(c_n);
      wr_ptr          <= wr_ptr + f_n;
      fl.overflow_err <= fl.overflow_err | drop;
      for (int s = 0; s < SS; s++) begin
        if (accept[s]) entry[w_idx[s]] <= fl.free_preg[s];
      end
    end
  end

  assign fl.alloc_ok   = alloc_ok;
  assign fl.free_count = free_count;

`ifdef FREE_LIST_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fl.stall_cycles <= '0;
    else if ((a_n != '0) && !fl.flush && !alloc_ok && (fl.stall_cycles != '1))
      fl.stall_cycles <= fl.stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_free_list.sv
// Directed-vector bench for free_list: allocation, exhaustion, flush, free/overflow, wrap.
module tb_free_list;
  import rv32i_types::*;

  logic clk, rst_n;
  int   pass_cnt, total_cnt;

  free_list_if fl();
  free_list dut (.clk(clk), .rst_n(rst_n), .fl(fl));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    fl.alloc_req = '0; fl.free_valid = '0; fl.free_preg = '0;
    fl.commit_alloc = '0; fl.flush = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0; #2; rst_n = 1'b1; #1;
  endtask

  // Allocate 31 entries: 15 pairs then one single.
  task automatic alloc31();
    fl.alloc_req = 2'b11;
    repeat (15) cyc();
    fl.alloc_req = 2'b01; cyc();
    fl.alloc_req = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (fl.free_count !== 6'd32) $display("FAIL reset_count got %0d want 32", fl.free_count); else pass_cnt++;
    total_cnt++; if (fl.overflow_err !== 1'b0) $display("FAIL reset_ovf got %0b want 0", fl.overflow_err); else pass_cnt++;
    total_cnt++; if (fl.alloc_ok !== 1'b1) $display("FAIL reset_n0_ok got %0b want 1", fl.alloc_ok); else pass_cnt++;
`ifdef FREE_LIST_STALL_CNT_EN
    total_cnt++; if (fl.stall_cycles !== 32'd0) $display("FAIL reset_stall got %0d want 0", fl.stall_cycles); else pass_cnt++;
`endif
  endtask

  task automatic test_alloc_pair();
    do_reset();
    fl.alloc_req = 2'b11; #1;
    total_cnt++; if (fl.alloc_ok !== 1'b1) $display("FAIL pair_ok got %0b want 1", fl.alloc_ok); else pass_cnt++;
    total_cnt++; if (fl.alloc_preg[0] !== 6'd32) $display("FAIL pair_p0 got %0d want 32", fl.alloc_preg[0]); else pass_cnt++;
    total_cnt++; if (fl.alloc_preg[1] !== 6'd33) $display("FAIL pair_p1 got %0d want 33", fl.alloc_preg[1]); else pass_cnt++;
    cyc(); fl.alloc_req = 2'b00; #1;
    total_cnt++; if (fl.free_count !== 6'd30) $display("FAIL pair_count got %0d want 30", fl.free_count); else pass_cnt++;
  endtask

  task automatic test_alloc_single_slot();
    do_reset();
    fl.alloc_req = 2'b10; #1;
    total_cnt++; if (fl.alloc_preg[1] !== 6'd32) $display("FAIL slot1_p1 got %0d want 32", fl.alloc_preg[1]); else pass_cnt++;
    total_cnt++; if (fl.alloc_preg[0] !== 6'd0) $display("FAIL slot1_p0 got %0d want 0", fl.alloc_preg[0]); else pass_cnt++;
    cyc(); fl.alloc_req = 2'b11; #1;
    total_cnt++; if (fl.alloc_preg[0] !== 6'd33) $display("FAIL next_p0 got %0d want 33", fl.alloc_preg[0]); else pass_cnt++;
    total_cnt++; if (fl.alloc_preg[1] !== 6'd34) $display("FAIL next_p1 got %0d want 34", fl.alloc_preg[1]); else pass_cnt++;
    cyc(); fl.alloc_req = 2'b00; #1;
    total_cnt++; if (fl.free_count !== 6'd29) $display("FAIL single_count got %0d want 29", fl.free_count); else pass_cnt++;
  endtask

  task automatic test_exhaust();
    do_reset();
    alloc31(); #1;
    total_cnt++; if (fl.free_count !== 6'd1) $display("FAIL exh_count1 got %0d want 1", fl.free_count); else pass_cnt++;
    fl.alloc_req = 2'b11; #1;
    total_cnt++; if (fl.alloc_ok !== 1'b0) $display("FAIL exh_ok got %0b want 0", fl.alloc_ok); else pass_cnt++;
    cyc(); fl.alloc_req = 2'b00; #1;
    total_cnt++; if (fl.free_count !== 6'd1) $display("FAIL exh_nochange got %0d want 1", fl.free_count); else pass_cnt++;
`ifdef FREE_LIST_STALL_CNT_EN
    total_cnt++; if (fl.stall_cycles !== 32'd1) $display("FAIL exh_stall got %0d want 1", fl.stall_cycles); else pass_cnt++;
`endif
    fl.alloc_req = 2'b01; #1;
    total_cnt++; if (fl.alloc_ok !== 1'b1) $display("FAIL last_ok got %0b want 1", fl.alloc_ok); else pass_cnt++;
    total_cnt++; if (fl.alloc_preg[0] !== 6'd63) $display("FAIL last_p0 got %0d want 63", fl.alloc_preg[0]); else pass_cnt++;
    cyc(); fl.alloc_req = 2'b00; #1;
    total_cnt++; if (fl.free_count !== 6'd0) $display("FAIL empty_count got %0d want 0", fl.free_count); else pass_cnt++;
    total_cnt++; if (fl.alloc_ok !== 1'b1) $display("FAIL empty_n0_ok got %0b want 1", fl.alloc_ok); else pass_cnt++;
    // Refill two entries across the index wrap, then drain them.
    fl.free_valid = 2'b11; fl.free_preg[0] = 6'd5; fl.free_preg[1] = 6'd7; #1;
    total_cnt++; if (fl.free_count !== 6'd0) $display("FAIL nobypass got %0d want 0", fl.free_count); else pass_cnt++;
    cyc(); idle(); #1;
    total_cnt++; if (fl.free_count !== 6'd2) $display("FAIL refill_count got %0d want 2", fl.free_count); else pass_cnt++;
    fl.alloc_req = 2'b11; #1;
    total_cnt++; if (fl.alloc_ok !== 1'b1) $display("FAIL refill_ok got %0b want 1", fl.alloc_ok); else pass_cnt++;
    total_cnt++; if (fl.alloc_preg[0] !== 6'd5) $display("FAIL refill_p0 got %0d want 5", fl.alloc_preg[0]); else pass_cnt++;
    total_cnt++; if (fl.alloc_preg[1] !== 6'd7) $display("FAIL refill_p1 got %0d want 7", fl.alloc_preg[1]); else pass_cnt++;
    cyc(); idle(); #1;
    total_cnt++; if (fl.free_count !== 6'd0) $display("FAIL redrain_count got %0d want 0", fl.free_count); else pass_cnt++;
    total_cnt++; if (fl.overflow_err !== 1'b0) $display("FAIL exh_ovf got %0b want 0", fl.overflow_err); else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    fl.alloc_req = 2'b11; cyc(); cyc();
    fl.alloc_req = 2'b00; fl.commit_alloc = 2'b01; cyc();
    fl.commit_alloc = 2'b00; #1;
    total_cnt++; if (fl.free_count !== 6'd28) $display("FAIL pre_flush got %0d want 28", fl.free_count); else pass_cnt++;
    fl.flush = 1'b1; fl.alloc_req = 2'b11; #1;
    total_cnt++; if (fl.alloc_ok !== 1'b0) $display("FAIL flush_ok got %0b want 0", fl.alloc_ok); else pass_cnt++;
    cyc(); idle(); #1;
    total_cnt++; if (fl.free_count !== 6'd31) $display("FAIL flush_count got %0d want 31", fl.free_count); else pass_cnt++;
    fl.alloc_req = 2'b01; #1;
    total_cnt++; if (fl.alloc_preg[0] !== 6'd33) $display("FAIL flush_next got %0d want 33", fl.alloc_preg[0]); else pass_cnt++;
    cyc(); idle(); #1;
    // rd=2, arch=1: flush with two same-cycle commits lands rd at 3.
    fl.flush = 1'b1; fl.commit_alloc = 2'b11; cyc(); idle(); #1;
    total_cnt++; if (fl.free_count !== 6'd29) $display("FAIL flush_commit got %0d want 29", fl.free_count); else pass_cnt++;
    fl.alloc_req = 2'b01; #1;
    total_cnt++; if (fl.alloc_preg[0] !== 6'd35) $display("FAIL flush_commit_p got %0d want 35", fl.alloc_preg[0]); else pass_cnt++;
    idle();
  endtask

  task automatic test_free_drop();
    do_reset();
    fl.free_valid = 2'b01; fl.free_preg[0] = 6'd0; cyc(); idle(); #1;
    total_cnt++; if (fl.overflow_err !== 1'b0) $display("FAIL zero_ovf got %0b want 0", fl.overflow_err); else pass_cnt++;
    total_cnt++; if (fl.free_count !== 6'd32) $display("FAIL zero_full got %0d want 32", fl.free_count); else pass_cnt++;
    fl.free_valid = 2'b01; fl.free_preg[0] = 6'd40; cyc(); idle(); #1;
    total_cnt++; if (fl.overflow_err !== 1'b1) $display("FAIL full_ovf got %0b want 1", fl.overflow_err); else pass_cnt++;
    total_cnt++; if (fl.free_count !== 6'd32) $display("FAIL full_count got %0d want 32", fl.free_count); else pass_cnt++;
    // Not full: a zero preg must still not enqueue.
    fl.alloc_req = 2'b11; cyc(); idle();
    fl.free_valid = 2'b10; fl.free_preg[1] = 6'd0; cyc(); idle(); #1;
    total_cnt++; if (fl.free_count !== 6'd30) $display("FAIL zero_partial got %0d want 30", fl.free_count); else pass_cnt++;
    total_cnt++; if (fl.overflow_err !== 1'b1) $display("FAIL ovf_sticky got %0b want 1", fl.overflow_err); else pass_cnt++;
    // One slot of room: second of two frees is dropped.
    do_reset();
    fl.alloc_req = 2'b01; cyc(); idle();
    fl.free_valid = 2'b11; fl.free_preg[0] = 6'd40; fl.free_preg[1] = 6'd41; cyc(); idle(); #1;
    total_cnt++; if (fl.free_count !== 6'd32) $display("FAIL part_count got %0d want 32", fl.free_count); else pass_cnt++;
    total_cnt++; if (fl.overflow_err !== 1'b1) $display("FAIL part_ovf got %0b want 1", fl.overflow_err); else pass_cnt++;
  endtask

  task automatic test_wrap_grant();
    do_reset();
    alloc31();
    fl.free_valid = 2'b11; fl.free_preg[0] = 6'd5; fl.free_preg[1] = 6'd7; cyc(); idle(); #1;
    total_cnt++; if (fl.free_count !== 6'd3) $display("FAIL wrap_count got %0d want 3", fl.free_count); else pass_cnt++;
    fl.alloc_req = 2'b11; #1;
    total_cnt++; if (fl.alloc_preg[0] !== 6'd63) $display("FAIL wrap_p0 got %0d want 63", fl.alloc_preg[0]); else pass_cnt++;
    total_cnt++; if (fl.alloc_preg[1] !== 6'd5) $display("FAIL wrap_p1 got %0d want 5", fl.alloc_preg[1]); else pass_cnt++;
    cyc(); fl.alloc_req = 2'b01; #1;
    total_cnt++; if (fl.alloc_preg[0] !== 6'd7) $display("FAIL wrap_tail got %0d want 7", fl.alloc_preg[0]); else pass_cnt++;
    cyc(); idle(); #1;
    total_cnt++; if (fl.free_count !== 6'd0) $display("FAIL wrap_empty got %0d want 0", fl.free_count); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b1; idle();
    @(posedge clk); #1;
    test_reset();
    test_alloc_pair();
    test_alloc_single_slot();
    test_exhaust();
    test_flush();
    test_free_drop();
    test_wrap_grant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
